// File: rtl/risc18_core.sv
// ---------------------------------------------------------------------------
// risc18_core : 16-bit teaching core running four packed instructions per load
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module risc18_core #(
   parameter int NSLOTS = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [63:0] PCin,
   output logic [15:0] ans,
   output logic [63:0] k,
   output logic        done
);

   localparam logic [3:0] c_op_add  = 4'h0;
   localparam logic [3:0] c_op_sub  = 4'h1;
   localparam logic [3:0] c_op_and  = 4'h2;
   localparam logic [3:0] c_op_or   = 4'h3;
   localparam logic [3:0] c_op_xor  = 4'h4;
   localparam logic [3:0] c_op_ldi  = 4'h5;
   localparam logic [3:0] c_op_shl  = 4'h6;
   localparam logic [3:0] c_op_shr  = 4'h7;
   localparam logic [3:0] c_op_mul  = 4'h8;
   localparam logic [3:0] c_op_not  = 4'h9;
   localparam logic [3:0] c_op_halt = 4'hF;
   localparam logic [1:0] c_last_slot = 2'(NSLOTS - 1);

   logic [1:0]  r_cnt;
   logic        r_ld;
   logic [15:0] r_rf [16];

   logic [3:0]  w_op, w_rd, w_rs1, w_rs2;
   logic [15:0] w_a, w_b, w_res, w_mul;
   logic        w_we, w_halt;

   assign w_op   = k[63:60];
   assign w_rd   = k[59:56];
   assign w_rs1  = k[55:52];
   assign w_rs2  = k[51:48];
   assign w_a    = r_rf[w_rs1];
   assign w_b    = r_rf[w_rs2];
   assign w_mul  = w_a * w_b;
   assign w_halt = (w_op == c_op_halt);

   // Opcodes A..F leave the register file and ans untouched.
   always_comb begin
      w_res = 16'h0000;
      w_we  = 1'b1;
      case (w_op)
         c_op_add: w_res = w_a + w_b;
         c_op_sub: w_res = w_a - w_b;
         c_op_and: w_res = w_a & w_b;
         c_op_or:  w_res = w_a | w_b;
         c_op_xor: w_res = w_a ^ w_b;
         c_op_ldi: w_res = {8'h00, w_rs1, w_rs2};
         c_op_shl: w_res = w_a << w_b[3:0];
         c_op_shr: w_res = w_a >> w_b[3:0];
         c_op_mul: w_res = w_mul;
         c_op_not: w_res = ~w_a;
         default:  w_we  = 1'b0;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         k     <= 64'h0;
         ans   <= 16'h0000;
         done  <= 1'b0;
         r_cnt <= 2'd0;
         r_ld  <= 1'b1;
         for (int i = 0; i < 16; i++) begin
            r_rf[i] <= 16'(i);
         end
      end else if (r_ld) begin
         k    <= PCin;
         r_ld <= 1'b0;
      end else if (!done) begin
         if (w_halt) begin
            // HALT parks itself at the head of k so it stays visible.
            done <= 1'b1;
         end else begin
            k     <= {k[47:0], 16'h0000};
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == c_last_slot) begin
               done <= 1'b1;
            end
            if (w_we) begin
               r_rf[w_rd] <= w_res;
               ans        <= w_res;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_risc18_core.sv
// Scoreboard bench for risc18_core: stimulus pushes expected state per edge,
// monitor compares on the falling edge.
`default_nettype none

module tb_risc18_core;

   logic        clock;
   logic        reset;
   logic [63:0] PCin;
   logic [15:0] ans;
   logic [63:0] k;
   logic        done;

   risc18_core #(.NSLOTS(4)) dut (
      .clock (clock),
      .reset (reset),
      .PCin  (PCin),
      .ans   (ans),
      .k     (k),
      .done  (done)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic [63:0] k;
      logic [15:0] ans;
      logic        done;
      string       tag;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Behavioural model: program as four slots plus a slot index.
   logic [15:0] m_prog [4];
   logic [15:0] m_rf   [16];
   logic [15:0] m_ans;
   int          m_slot;
   bit          m_loaded;
   bit          m_halt;

   function automatic bit m_done();
      return m_halt || (m_slot == 4);
   endfunction

   function automatic logic [63:0] m_k();
      logic [63:0] kk;
      kk = 64'h0;
      for (int i = m_slot; i < 4; i++) begin
         kk[63 - 16*(i - m_slot) -: 16] = m_prog[i];
      end
      return kk;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_rf[i] = 16'(i);
      for (int i = 0; i < 4; i++) m_prog[i] = 16'h0;
      m_ans = 16'h0; m_slot = 0; m_loaded = 0; m_halt = 0;
   endtask

   task automatic model_edge();
      logic [15:0] ins, a, b, r;
      logic [31:0] p;
      int op;
      bit wr;
      if (!m_loaded) begin
         for (int i = 0; i < 4; i++) m_prog[i] = PCin[63 - 16*i -: 16];
         m_loaded = 1;
      end else if (!m_done()) begin
         ins = m_prog[m_slot];
         op  = int'(ins[15:12]);
         a   = m_rf[ins[7:4]];
         b   = m_rf[ins[3:0]];
         wr  = 1;
         r   = 16'h0;
         case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = {8'h00, ins[7:0]};
            6: r = a << b[3:0];
            7: r = a >> b[3:0];
            8: begin p = {16'h0, a} * {16'h0, b}; r = p[15:0]; end
            9: r = ~a;
            default: wr = 0;
         endcase
         if (op == 15) begin
            m_halt = 1;
         end else begin
            if (wr) begin
               m_rf[ins[11:8]] = r;
               m_ans = r;
            end
            m_slot++;
         end
      end
   endtask

   task automatic push_exp(input string tag);
      exp_t e;
      e.k = m_k(); e.ans = m_ans; e.done = m_done(); e.tag = tag;
      q.push_back(e);
   endtask

   task automatic apply_reset(input string tag);
      @(negedge clock);
      #2 reset = 1'b0;
      model_reset();
      #1 push_exp(tag);
      @(negedge clock);
      #2 reset = 1'b1;
   endtask

   task automatic step(input string tag);
      @(posedge clock);
      model_edge();
      #1 push_exp(tag);
   endtask

   task automatic run_prog(input logic [63:0] pc, input int nedges, input string tag);
      apply_reset({tag, "_rst"});
      PCin = pc;
      for (int i = 0; i < nedges; i++) step($sformatf("%s_e%0d", tag, i + 1));
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.tag, ".k"},    k,           e.k);
            chk({e.tag, ".ans"},  {48'h0, ans}, {48'h0, e.ans});
            chk({e.tag, ".done"}, {63'h0, done}, {63'h0, e.done});
         end
      end
   end

   initial begin
      logic [63:0] pc;
      reset = 1'b1;
      PCin  = 64'h0;
      model_reset();

      run_prog(64'h0101_5600_0211_0000, 6, "p1");
      run_prog(64'h5A7F_0123_8A21_F000, 7, "p2");
      run_prog(64'h1012_9300_0000_0000, 5, "p3");
      run_prog(64'h1111_1111_1111_1111, 6, "p4");

      // Abort mid-program, then a fresh program must see a clean register file.
      run_prog(64'h0101_0211_0322_0433, 3, "p5");
      run_prog(64'h6312_0000_0000_0000, 5, "p6");

      // PCin changes after the load edge must be ignored.
      apply_reset("p7_rst");
      PCin = 64'h5A7F_0123_8A21_0AA0;
      step("p7_e1");
      PCin = 64'h9000_9111_9222_9333;
      for (int i = 2; i <= 5; i++) step($sformatf("p7_e%0d", i));

      for (int t = 0; t < 24; t++) begin
         pc = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) pc[63 - 16*$urandom_range(0, 3) -: 4] = 4'hF;
         apply_reset($sformatf("r%0d_rst", t));
         PCin = pc;
         step($sformatf("r%0d_e1", t));
         PCin = {$urandom, $urandom};
         for (int i = 2; i <= 6; i++) begin
            if ((t % 5 == 4) && (i == 4)) break;
            step($sformatf("r%0d_e%0d", t, i));
         end
      end

      repeat (3) @(negedge clock);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
